// File: rtl/input_filter_sched.sv
// Time-multiplexed glitch filter: one sequenced evaluator sweeps NUM_CH synchronised inputs per prescaler tick.
// Optional sticky change flags with write-1-to-clear ack and a registered irq are enabled by defining FILTER_IRQ_EN.
module input_filter_sched #(
  parameter int NUM_CH     = 8,
  parameter int FILTER_LEN = 5,
  parameter int PRESCALE   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] in_i,
  output logic [NUM_CH-1:0] out_o,
  output logic [NUM_CH-1:0] changed_o,
  output logic              sweep_done_o,
  output logic              busy_o
`ifdef FILTER_IRQ_EN
  ,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic              irq_o
`endif
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);

  // A tick during SCAN/DONE would be lost, so the sweep must fit between ticks.
  if (PRESCALE < NUM_CH + 2) begin : g_bad_prescale
    $error("input_filter_sched: PRESCALE must be >= NUM_CH+2");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("input_filter_sched: NUM_CH must be in 1..32");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : g_bad_filter_len
    $error("input_filter_sched: FILTER_LEN must be in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CH-1:0]       sync1_q, sync_q;
  logic [NUM_CH-1:0]       snap_q, snap_d;
  logic [NUM_CH-1:0]       out_q, out_d;
  logic [NUM_CH-1:0]       changed_q, changed_d;
  logic                    sweep_done_q, sweep_done_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    tick;
  logic [FILTER_LEN-1:0]   hist_q [NUM_CH];
  logic [FILTER_LEN-1:0]   hist_new;
  logic                    hist_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= in_i;
      sync_q  <= sync1_q;
      cnt_q   <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      out_q        <= '0;
      changed_q    <= '0;
      sweep_done_q <= 1'b0;
      // NOTE: histories are reset so every channel restarts filtering from a known all-zero state.
      for (int k = 0; k < NUM_CH; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      out_q        <= out_d;
      changed_q    <= changed_d;
      sweep_done_q <= sweep_done_d;
      if (hist_we) begin
        hist_q[idx_q] <= hist_new;
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    out_d        = out_q;
    changed_d    = '0;
    sweep_done_d = 1'b0;
    hist_we      = 1'b0;
    hist_new     = {hist_q[idx_q][FILTER_LEN-2:0], snap_q[idx_q]};

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d  = sync_q;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        hist_we = 1'b1;
        // Set/reset filter: flip only on a full run of equal samples, otherwise hold.
        if (&hist_new) begin
          out_d[idx_q] = 1'b1;
        end else if (~|hist_new) begin
          out_d[idx_q] = 1'b0;
        end
        changed_d[idx_q] = out_d[idx_q] ^ out_q[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        sweep_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_o        = out_q;
  assign changed_o    = changed_q;
  assign sweep_done_o = sweep_done_q;
  assign busy_o       = (state_q != IDLE);

`ifdef FILTER_IRQ_EN
  logic [NUM_CH-1:0] pending_q;
  logic              irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      // A new change in the same cycle as its ack must not be lost, so set wins.
      pending_q <= changed_q | (pending_q & ~ack_i);
      irq_q     <= |pending_q;
    end
  end

  assign pending_o = pending_q;
  assign irq_o     = irq_q;
`endif

endmodule
